// File: rtl/bp_be_fe_branch_resolver.sv
// Backend branch resolver: compares resolved next-PC with the frontend
// prediction, issues redirects on mispredicts and queues attaboy hints.
module bp_be_fe_branch_resolver #(
    parameter int vaddr_width_p               = 39,
    parameter int branch_metadata_fwd_width_p = 16,
    parameter int src_btb_bit_p               = 0,
    parameter int attaboy_fifo_els_p          = 4,
    parameter int cnt_width_p                 = 16
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic                                   br_v_i,
    input  logic [vaddr_width_p-1:0]               br_pc_i,
    input  logic [vaddr_width_p-1:0]               br_pred_npc_i,
    input  logic [vaddr_width_p-1:0]               br_tgt_i,
    input  logic                                   br_taken_i,
    input  logic                                   br_site_br_i,
    input  logic                                   br_site_jmp_i,
    input  logic [branch_metadata_fwd_width_p-1:0] br_metadata_fwd_i,
    input  logic                                   ext_redirect_v_i,
    input  logic [vaddr_width_p-1:0]               ext_redirect_pc_i,
    input  logic                                   squash_done_i,
    output logic                                   redirect_v_o,
    output logic [vaddr_width_p-1:0]               redirect_pc_o,
    output logic                                   redirect_br_v_o,
    output logic [branch_metadata_fwd_width_p-1:0] redirect_br_metadata_fwd_o,
    output logic                                   redirect_br_taken_o,
    output logic                                   redirect_br_ntaken_o,
    output logic                                   redirect_br_nonbr_o,
    output logic                                   attaboy_v_o,
    output logic [vaddr_width_p-1:0]               attaboy_pc_o,
    output logic [branch_metadata_fwd_width_p-1:0] attaboy_br_metadata_fwd_o,
    output logic                                   attaboy_taken_o,
    output logic                                   attaboy_ntaken_o,
    input  logic                                   attaboy_yumi_i,
    output logic                                   squash_o,
    output logic [cnt_width_p-1:0]                 mispredict_cnt_o,
    output logic [cnt_width_p-1:0]                 attaboy_drop_cnt_o
);

    localparam int ptr_w_lp = $clog2(attaboy_fifo_els_p);

    typedef enum logic {e_run, e_squash} state_e;

    state_e state_r, state_n;

    logic [vaddr_width_p-1:0] pc_plus4, actual_npc;
    logic ctl, nonbr_err, mispredict, br_act, br_redirect, issue, enq;
    logic taken, ntaken;

    logic                                   redir_v_n, redir_br_v_n;
    logic [vaddr_width_p-1:0]               redir_pc_n;
    logic [branch_metadata_fwd_width_p-1:0] redir_md_n;
    logic                                   redir_tk_n, redir_nt_n, redir_nb_n;

    logic [ptr_w_lp:0] wptr_r, rptr_r;
    logic [ptr_w_lp-1:0] widx, ridx;
    logic full, empty, pop, push, drop;

    logic [vaddr_width_p-1:0]               pc_mem [attaboy_fifo_els_p];
    logic [branch_metadata_fwd_width_p-1:0] md_mem [attaboy_fifo_els_p];
    logic                                   tk_mem [attaboy_fifo_els_p];
    logic                                   nt_mem [attaboy_fifo_els_p];

    assign pc_plus4    = br_pc_i + vaddr_width_p'(4);
    assign taken       = br_site_jmp_i | (br_site_br_i & br_taken_i);
    assign ntaken      = br_site_br_i & ~br_taken_i;
    assign actual_npc  = taken ? br_tgt_i : pc_plus4;
    assign ctl         = br_site_br_i | br_site_jmp_i;
    assign nonbr_err   = ~ctl & br_metadata_fwd_i[src_btb_bit_p];
    assign mispredict  = (ctl & (actual_npc != br_pred_npc_i)) | nonbr_err;
    // An ext redirect in the same cycle kills the branch entirely
    assign br_act      = (state_r == e_run) & br_v_i & ~ext_redirect_v_i;
    assign br_redirect = br_act & mispredict;
    assign issue       = ext_redirect_v_i | br_redirect;
    assign enq         = br_act & ctl & ~mispredict;

    assign widx  = wptr_r[ptr_w_lp-1:0];
    assign ridx  = rptr_r[ptr_w_lp-1:0];
    assign empty = (wptr_r == rptr_r);
    assign full  = (wptr_r[ptr_w_lp] != rptr_r[ptr_w_lp]) && (widx == ridx);
    assign pop   = attaboy_yumi_i & ~empty;
    assign push  = enq & (~full | pop);
    assign drop  = enq & full & ~pop;

    assign attaboy_v_o               = ~empty;
    assign attaboy_pc_o              = empty ? '0 : pc_mem[ridx];
    assign attaboy_br_metadata_fwd_o = empty ? '0 : md_mem[ridx];
    assign attaboy_taken_o           = ~empty & tk_mem[ridx];
    assign attaboy_ntaken_o          = ~empty & nt_mem[ridx];
    assign squash_o                  = (state_r == e_squash);

    // Next state: any redirect enters SQUASH and wins over squash_done
    always_comb begin
        state_n = state_r;
        case (state_r)
            e_run:    if (issue) state_n = e_squash;
            e_squash: if (!issue && squash_done_i) state_n = e_run;
            default:  state_n = e_run;
        endcase
    end

    // Redirect payload selection, ext redirect has priority
    always_comb begin
        redir_v_n    = 1'b0;
        redir_br_v_n = 1'b0;
        redir_pc_n   = '0;
        redir_md_n   = '0;
        redir_tk_n   = 1'b0;
        redir_nt_n   = 1'b0;
        redir_nb_n   = 1'b0;
        if (ext_redirect_v_i) begin
            redir_v_n  = 1'b1;
            redir_pc_n = ext_redirect_pc_i;
        end else if (br_redirect) begin
            redir_v_n    = 1'b1;
            redir_br_v_n = 1'b1;
            redir_pc_n   = actual_npc;
            redir_md_n   = br_metadata_fwd_i;
            redir_tk_n   = ctl & taken;
            redir_nt_n   = ntaken;
            redir_nb_n   = nonbr_err;
        end
    end

    // State, registered redirect pulse, FIFO pointers and counters
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r                    <= e_run;
            redirect_v_o               <= 1'b0;
            redirect_pc_o              <= '0;
            redirect_br_v_o            <= 1'b0;
            redirect_br_metadata_fwd_o <= '0;
            redirect_br_taken_o        <= 1'b0;
            redirect_br_ntaken_o       <= 1'b0;
            redirect_br_nonbr_o        <= 1'b0;
            wptr_r                     <= '0;
            rptr_r                     <= '0;
            mispredict_cnt_o           <= '0;
            attaboy_drop_cnt_o         <= '0;
        end else begin
            state_r                    <= state_n;
            redirect_v_o               <= redir_v_n;
            redirect_pc_o              <= redir_pc_n;
            redirect_br_v_o            <= redir_br_v_n;
            redirect_br_metadata_fwd_o <= redir_md_n;
            redirect_br_taken_o        <= redir_tk_n;
            redirect_br_ntaken_o       <= redir_nt_n;
            redirect_br_nonbr_o        <= redir_nb_n;
            if (push) wptr_r <= wptr_r + (ptr_w_lp+1)'(1);
            if (pop)  rptr_r <= rptr_r + (ptr_w_lp+1)'(1);
            if (br_redirect && (mispredict_cnt_o != '1))
                mispredict_cnt_o <= mispredict_cnt_o + cnt_width_p'(1);
            if (drop && (attaboy_drop_cnt_o != '1))
                attaboy_drop_cnt_o <= attaboy_drop_cnt_o + cnt_width_p'(1);
        end
    end

    // FIFO storage, validity is tracked by the pointers
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[widx] <= actual_npc;
            md_mem[widx] <= br_metadata_fwd_i;
            tk_mem[widx] <= taken;
            nt_mem[widx] <= ntaken;
        end
    end

endmodule

// File: tb/tb_bp_be_fe_branch_resolver.sv
// Directed bench for bp_be_fe_branch_resolver with redirect and
// attaboy scoreboards checked by immediate assertions.
module tb_bp_be_fe_branch_resolver;

    localparam int VW = 39;
    localparam int MW = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          br_v_i;
    logic [VW-1:0] br_pc_i, br_pred_npc_i, br_tgt_i;
    logic          br_taken_i, br_site_br_i, br_site_jmp_i;
    logic [MW-1:0] br_metadata_fwd_i;
    logic          ext_redirect_v_i;
    logic [VW-1:0] ext_redirect_pc_i;
    logic          squash_done_i;
    logic          redirect_v_o;
    logic [VW-1:0] redirect_pc_o;
    logic          redirect_br_v_o;
    logic [MW-1:0] redirect_br_metadata_fwd_o;
    logic          redirect_br_taken_o, redirect_br_ntaken_o, redirect_br_nonbr_o;
    logic          attaboy_v_o;
    logic [VW-1:0] attaboy_pc_o;
    logic [MW-1:0] attaboy_br_metadata_fwd_o;
    logic          attaboy_taken_o, attaboy_ntaken_o;
    logic          attaboy_yumi_i;
    logic          squash_o;
    logic [CW-1:0] mispredict_cnt_o, attaboy_drop_cnt_o;

    always #5 clk = ~clk;

    bp_be_fe_branch_resolver #(
        .vaddr_width_p(VW), .branch_metadata_fwd_width_p(MW),
        .src_btb_bit_p(0), .attaboy_fifo_els_p(4), .cnt_width_p(CW)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .br_v_i(br_v_i), .br_pc_i(br_pc_i),
        .br_pred_npc_i(br_pred_npc_i), .br_tgt_i(br_tgt_i),
        .br_taken_i(br_taken_i), .br_site_br_i(br_site_br_i),
        .br_site_jmp_i(br_site_jmp_i),
        .br_metadata_fwd_i(br_metadata_fwd_i),
        .ext_redirect_v_i(ext_redirect_v_i),
        .ext_redirect_pc_i(ext_redirect_pc_i),
        .squash_done_i(squash_done_i),
        .redirect_v_o(redirect_v_o), .redirect_pc_o(redirect_pc_o),
        .redirect_br_v_o(redirect_br_v_o),
        .redirect_br_metadata_fwd_o(redirect_br_metadata_fwd_o),
        .redirect_br_taken_o(redirect_br_taken_o),
        .redirect_br_ntaken_o(redirect_br_ntaken_o),
        .redirect_br_nonbr_o(redirect_br_nonbr_o),
        .attaboy_v_o(attaboy_v_o), .attaboy_pc_o(attaboy_pc_o),
        .attaboy_br_metadata_fwd_o(attaboy_br_metadata_fwd_o),
        .attaboy_taken_o(attaboy_taken_o),
        .attaboy_ntaken_o(attaboy_ntaken_o),
        .attaboy_yumi_i(attaboy_yumi_i),
        .squash_o(squash_o),
        .mispredict_cnt_o(mispredict_cnt_o),
        .attaboy_drop_cnt_o(attaboy_drop_cnt_o)
    );

    typedef struct {
        logic [VW-1:0] pc;
        logic          br_v;
        logic [MW-1:0] md;
        logic          tk, nt, nb;
    } redir_t;

    typedef struct {
        logic [VW-1:0] pc;
        logic [MW-1:0] md;
        logic          tk, nt;
    } att_t;

    redir_t rq[$];
    att_t   aq[$];
    int     n_assert = 0;
    int     n_fail   = 0;
    logic   exp_sq   = 1'b0;
    int     exp_mis  = 0;
    int     exp_drop = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        br_v_i = 0; br_pc_i = '0; br_pred_npc_i = '0; br_tgt_i = '0;
        br_taken_i = 0; br_site_br_i = 0; br_site_jmp_i = 0;
        br_metadata_fwd_i = '0; ext_redirect_v_i = 0;
        ext_redirect_pc_i = '0; squash_done_i = 0; attaboy_yumi_i = 0;
    endtask

    // One clock, then compare registered outputs against the scoreboards
    task automatic step();
        redir_t r;
        @(posedge clk); #1;
        chk("redirect_v", redirect_v_o, 64'(rq.size()));
        if (rq.size() != 0) begin
            r = rq.pop_front();
            chk("redirect_pc", redirect_pc_o, r.pc);
            chk("redirect_br_v", redirect_br_v_o, r.br_v);
            chk("redirect_md", redirect_br_metadata_fwd_o, r.md);
            chk("redirect_taken", redirect_br_taken_o, r.tk);
            chk("redirect_ntaken", redirect_br_ntaken_o, r.nt);
            chk("redirect_nonbr", redirect_br_nonbr_o, r.nb);
        end else begin
            chk("redirect_pc_idle", redirect_pc_o, 0);
            chk("redirect_br_v_idle", redirect_br_v_o, 0);
        end
        chk("attaboy_v", attaboy_v_o, aq.size() != 0);
        chk("squash", squash_o, exp_sq);
        chk("mispredict_cnt", mispredict_cnt_o, exp_mis);
        chk("drop_cnt", attaboy_drop_cnt_o, exp_drop);
        clear_inputs();
    endtask

    // Drive one cycle of stimulus and push the expected results
    task automatic drive(input logic bv, input logic [VW-1:0] pc,
                         input logic [VW-1:0] pred, input logic [VW-1:0] tgt,
                         input logic tk, input logic sbr, input logic sjmp,
                         input logic [MW-1:0] md, input logic ev,
                         input logic [VW-1:0] epc, input logic yumi,
                         input logic sqd);
        logic [VW-1:0] p4, npc;
        logic          is_ctl, nbe, mis, live, redir;
        redir_t        r;
        att_t          a;
        br_v_i = bv; br_pc_i = pc; br_pred_npc_i = pred; br_tgt_i = tgt;
        br_taken_i = tk; br_site_br_i = sbr; br_site_jmp_i = sjmp;
        br_metadata_fwd_i = md; ext_redirect_v_i = ev;
        ext_redirect_pc_i = epc; attaboy_yumi_i = yumi;
        squash_done_i = sqd;
        p4     = pc + VW'(4);
        npc    = (sjmp || (sbr && tk)) ? tgt : p4;
        is_ctl = sbr | sjmp;
        nbe    = !is_ctl && md[0];
        mis    = (is_ctl && npc != pred) || nbe;
        live   = bv && !exp_sq && !ev;
        redir  = ev || (live && mis);
        if (ev) begin
            r = '{pc: epc, br_v: 0, md: '0, tk: 0, nt: 0, nb: 0};
            rq.push_back(r);
        end else if (live && mis) begin
            r = '{pc: npc, br_v: 1, md: md, tk: is_ctl && (sjmp || tk),
                  nt: sbr && !tk, nb: nbe};
            rq.push_back(r);
            exp_mis++;
        end
        if (yumi) begin
            chk("yumi_head_v", attaboy_v_o, 1);
            if (aq.size() != 0) begin
                a = aq.pop_front();
                chk("attaboy_pc", attaboy_pc_o, a.pc);
                chk("attaboy_md", attaboy_br_metadata_fwd_o, a.md);
                chk("attaboy_taken", attaboy_taken_o, a.tk);
                chk("attaboy_ntaken", attaboy_ntaken_o, a.nt);
            end
        end
        if (live && is_ctl && !mis) begin
            if (aq.size() < 4) begin
                a = '{pc: npc, md: md, tk: sjmp || tk, nt: sbr && !tk};
                aq.push_back(a);
            end else begin
                exp_drop++;
            end
        end
        if (redir) exp_sq = 1'b1;
        else if (sqd) exp_sq = 1'b0;
        step();
    endtask

    task automatic idle(input logic yumi, input logic sqd);
        drive(0, '0, '0, '0, 0, 0, 0, '0, 0, '0, yumi, sqd);
    endtask

    initial begin
        clear_inputs();
        reset_i = 1'b1;
        #12;
        chk("reset_redirect_v", redirect_v_o, 0);
        chk("reset_attaboy_v", attaboy_v_o, 0);
        chk("reset_squash", squash_o, 0);
        chk("reset_mis_cnt", mispredict_cnt_o, 0);
        chk("reset_drop_cnt", attaboy_drop_cnt_o, 0);
        @(negedge clk);
        reset_i = 1'b0;
        @(posedge clk); #1;

        // Correctly predicted taken branch
        drive(1, 39'h1000, 39'h1040, 39'h1040, 1, 1, 0, 16'h00a2,
              0, '0, 0, 0);
        chk("t1_att_v", attaboy_v_o, 1);
        chk("t1_att_pc", attaboy_pc_o, 39'h1040);
        chk("t1_att_taken", attaboy_taken_o, 1);
        idle(1, 0);
        chk("t1_att_v_after_pop", attaboy_v_o, 0);

        // Mispredicted not-taken branch, then squash
        drive(1, 39'h2000, 39'h2080, 39'h2040, 0, 1, 0, 16'h0010,
              0, '0, 0, 0);
        chk("t2_redirect_pc", redirect_pc_o, 39'h2004);
        chk("t2_ntaken", redirect_br_ntaken_o, 1);
        chk("t2_squash", squash_o, 1);
        drive(1, 39'h2100, 39'h0, 39'h2200, 1, 1, 0, 16'h0, 0, '0, 0, 0);
        idle(0, 1);
        chk("t2_squash_clear", squash_o, 0);
        chk("t2_mis_cnt", mispredict_cnt_o, 1);

        // Non-branch with src_btb set, then clear
        drive(1, 39'h3000, 39'h3100, 39'h0, 0, 0, 0, 16'h0001,
              0, '0, 0, 0);
        chk("t3_redirect_pc", redirect_pc_o, 39'h3004);
        chk("t3_nonbr", redirect_br_nonbr_o, 1);
        idle(0, 1);
        drive(1, 39'h3000, 39'h3100, 39'h0, 0, 0, 0, 16'h0000,
              0, '0, 0, 0);

        // Ext redirect beats a same-cycle mispredict
        drive(1, 39'h4000, 39'h4000, 39'h4100, 1, 1, 0, 16'h0004,
              1, 39'h8000_0000, 0, 0);
        chk("t4_redirect_pc", redirect_pc_o, 39'h8000_0000);
        chk("t4_br_v", redirect_br_v_o, 0);
        chk("t4_mis_cnt", mispredict_cnt_o, 2);
        drive(0, '0, '0, '0, 0, 0, 0, '0, 1, 39'h9000, 0, 1);
        chk("t4_squash_hold", squash_o, 1);
        idle(0, 1);

        // Fill FIFO, drop one, then enqueue with a same-cycle pop
        for (int i = 0; i < 5; i++)
            drive(1, 39'h5000 + VW'(i * 16), 39'h5800 + VW'(i * 16),
                  39'h5800 + VW'(i * 16), 1, 1, 0, MW'(16'h0100 + i),
                  0, '0, 0, 0);
        chk("t5_drop_cnt", attaboy_drop_cnt_o, 1);
        drive(1, 39'h5050, 39'h5850, 39'h5850, 1, 1, 0, 16'h0105,
              0, '0, 1, 0);
        chk("t5_drop_cnt_same", attaboy_drop_cnt_o, 1);
        for (int i = 0; i < 4; i++) idle(1, 0);
        chk("t5_drained", attaboy_v_o, 0);

        // Address wrap on pc+4
        drive(1, 39'h7F_FFFF_FFFC, 39'h0, 39'h1234, 0, 1, 0, 16'h0200,
              0, '0, 0, 0);
        chk("t6_att_pc", attaboy_pc_o, 0);
        chk("t6_att_ntaken", attaboy_ntaken_o, 1);
        idle(1, 0);

        // Asynchronous reset with entries queued
        drive(1, 39'h6000, 39'h6004, 39'h6100, 0, 1, 0, 16'h0300,
              0, '0, 0, 0);
        drive(1, 39'h6010, 39'h6100, 39'h6100, 0, 0, 1, 16'h0301,
              0, '0, 0, 0);
        #2 reset_i = 1'b1;
        #1;
        chk("t7_att_v_async", attaboy_v_o, 0);
        chk("t7_mis_cnt", mispredict_cnt_o, 0);
        chk("t7_drop_cnt", attaboy_drop_cnt_o, 0);
        aq.delete();
        rq.delete();
        exp_sq = 1'b0; exp_mis = 0; exp_drop = 0;
        @(negedge clk);
        reset_i = 1'b0;
        @(posedge clk); #1;
        idle(0, 0);

        chk("redirect_queue_empty", 64'(rq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
